// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request arbiter.
package dma_pkg;
   localparam int NCH  = 4;
   localparam int CH_W = 2;

   localparam int CMD_DIS        = 2;
   localparam int CMD_ROT        = 4;
   localparam int CMD_DREQ_SENSE = 6;
   localparam int CMD_DACK_SENSE = 7;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_SVC   = 2'd2
   } arb_state_t;
endpackage

// File: rtl/dma_priority_rotator.sv
// Combinational priority pick: first requesting channel scanning up from ptr, modulo 4.
module dma_priority_rotator
   import dma_pkg::*;
(
   input  logic [NCH-1:0]  req,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] win,
   output logic            any
);

   logic [CH_W-1:0] idx;

   // Walk from the lowest-priority offset down so the highest-priority hit is written last.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = ptr + i[CH_W-1:0];
         if (req[idx]) win = idx;
      end
   end

   assign any = |req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style request arbitration: samples DREQ/software requests, picks a winner
// by fixed or rotating priority, and holds it through the timing-control service cycle.
module dma_priority_arbiter
   import dma_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [NCH-1:0]  DREQ,
   input  logic [7:0]      commandReg,
   input  logic [NCH-1:0]  maskReg,
   input  logic [NCH-1:0]  requestReg,
   input  logic            Program,
   input  logic            validDACK,
   input  logic            cycleDone,
   input  logic            tcReached,
   output logic [NCH-1:0]  VALID_DREQ,
   output logic [NCH-1:0]  DACK,
   output logic [CH_W-1:0] activeCh,
   output logic [NCH-1:0]  clrReq,
   output logic            busy
);

   arb_state_t      state_q, state_d;
   logic [NCH-1:0]  req_q, req_d;
   logic [CH_W-1:0] grant_q, grant_d;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [NCH-1:0]  clr_q, clr_d;
   logic [CH_W-1:0] win;
   logic            any;
   logic [NCH-1:0]  grant_oh;
   logic            unused_cmd;

   assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

   dma_priority_rotator u_rot (
      .req (req_q),
      .ptr (ptr_q),
      .win (win),
      .any (any)
   );

   assign grant_oh = NCH'(1) << grant_q;

   always_comb begin
      req_d   = ((DREQ ^ {NCH{commandReg[CMD_DREQ_SENSE]}}) & ~maskReg) | requestReg;
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = commandReg[CMD_ROT] ? ptr_q : '0;
      clr_d   = '0;
      case (state_q)
         ARB_IDLE: begin
            // Disable/Program only gate new grants; an in-flight service always finishes.
            if (any && !commandReg[CMD_DIS] && !Program) begin
               state_d = ARB_GRANT;
               grant_d = win;
            end
         end
         ARB_GRANT: begin
            if (validDACK) state_d = ARB_SVC;
         end
         ARB_SVC: begin
            if (cycleDone) begin
               state_d = ARB_IDLE;
               if (commandReg[CMD_ROT]) ptr_d = grant_q + CH_W'(1);
               if (tcReached && requestReg[grant_q]) clr_d = grant_oh;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= ARB_IDLE;
         req_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      DACK = {NCH{~commandReg[CMD_DACK_SENSE]}};
      if (state_q == ARB_SVC) DACK[grant_q] = commandReg[CMD_DACK_SENSE];
   end

   assign VALID_DREQ = (state_q != ARB_IDLE) ? grant_oh : '0;
   assign activeCh   = grant_q;
   assign clrReq     = clr_q;
   assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter; expected grants are queued as stimulus is applied.
module tb_dma_priority_arbiter;

   logic       CLK, RESET_N;
   logic [3:0] DREQ, maskReg, requestReg;
   logic [7:0] commandReg;
   logic       Program, validDACK, cycleDone, tcReached;
   logic [3:0] VALID_DREQ, DACK, clrReq;
   logic [1:0] activeCh;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;
   int unsigned sb[$];
   int lat;

   dma_priority_arbiter #(.NCH(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .commandReg(commandReg),
      .maskReg(maskReg), .requestReg(requestReg), .Program(Program),
      .validDACK(validDACK), .cycleDone(cycleDone), .tcReached(tcReached),
      .VALID_DREQ(VALID_DREQ), .DACK(DACK), .activeCh(activeCh),
      .clrReq(clrReq), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int ch);
      logic [3:0] one;
      one = 4'b0001;
      return one << ch;
   endfunction

   function automatic logic [3:0] dack_inact();
      return {4{~commandReg[7]}};
   endfunction

   function automatic logic [3:0] dack_act(input int ch);
      return commandReg[7] ? oh(ch) : ~oh(ch);
   endfunction

   // Polls (bounded) for a grant, then checks it against the head of the scoreboard.
   task automatic wait_grant(input string tag, output int n);
      int unsigned e;
      n = 0;
      do begin
         tick();
         n++;
      end while (VALID_DREQ == 4'b0 && n < 10);
      e = (sb.size() != 0) ? sb.pop_front() : 0;
      chk({tag, "_valid"}, {4'b0, VALID_DREQ}, {4'b0, oh(int'(e))});
      chk({tag, "_ch"}, {6'b0, activeCh}, 8'(e));
      chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
   endtask

   task automatic ack(input int ch);
      validDACK = 1'b1;
      tick();
      validDACK = 1'b0;
      chk("ack_dack", {4'b0, DACK}, {4'b0, dack_act(ch)});
      chk("ack_valid", {4'b0, VALID_DREQ}, {4'b0, oh(ch)});
   endtask

   task automatic done(input int ch, input bit tc, input logic [3:0] dnext);
      logic [3:0] cexp;
      cexp = (tc && requestReg[ch]) ? oh(ch) : 4'b0;
      cycleDone = 1'b1;
      tcReached = tc;
      DREQ      = dnext;
      tick();
      cycleDone = 1'b0;
      tcReached = 1'b0;
      chk("done_valid", {4'b0, VALID_DREQ}, 8'd0);
      chk("done_dack", {4'b0, DACK}, {4'b0, dack_inact()});
      chk("done_clr", {4'b0, clrReq}, {4'b0, cexp});
   endtask

   initial begin
      RESET_N = 1'b0; DREQ = 4'b1111; commandReg = 8'h00; maskReg = 4'b0;
      requestReg = 4'b0; Program = 1'b0; validDACK = 1'b0; cycleDone = 1'b0; tcReached = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_dack", {4'b0, DACK}, 8'h0f);
      chk("rst_valid", {4'b0, VALID_DREQ}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'd0);
      chk("rst_ch", {6'b0, activeCh}, 8'd0);
      chk("rst_clr", {4'b0, clrReq}, 8'h00);
      RESET_N = 1'b1;
      tick();
      chk("rel_e1_valid", {4'b0, VALID_DREQ}, 8'h00);
      sb.push_back(0);
      wait_grant("rel_e2", lat);
      chk("rel_lat", 8'(lat), 8'd1);
      ack(0);
      done(0, 1'b0, 4'b0000);
      tick();
      chk("idle_busy", {7'b0, busy}, 8'd0);

      // Fixed priority
      DREQ = 4'b1010;
      sb.push_back(1);
      wait_grant("fix1", lat);
      chk("fix1_lat", 8'(lat), 8'd2);
      ack(1);
      chk("fix1_dack", {4'b0, DACK}, 8'h0d);
      done(1, 1'b0, 4'b1010);
      sb.push_back(1);
      wait_grant("fix2", lat);
      chk("fix2_lat", 8'(lat), 8'd1);
      ack(1);
      done(1, 1'b0, 4'b0000);

      // Rotating priority
      commandReg = 8'h10;
      DREQ = 4'b1111;
      sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
      for (int k = 0; k < 5; k++) begin
         wait_grant("rot", lat);
         ack(int'(activeCh));
         done(int'(activeCh), 1'b0, (k == 4) ? 4'b0000 : 4'b1111);
      end
      commandReg = 8'h00;
      tick();

      // Masking and software requests
      maskReg = 4'b0100;
      DREQ = 4'b0100;
      repeat (4) tick();
      chk("mask_busy", {7'b0, busy}, 8'd0);
      chk("mask_valid", {4'b0, VALID_DREQ}, 8'h00);
      requestReg = 4'b0100;
      sb.push_back(2);
      wait_grant("swreq", lat);
      ack(2);
      done(2, 1'b1, 4'b0100);
      requestReg = 4'b0000;
      sb.push_back(2);
      wait_grant("swreq_again", lat);
      chk("clr_one_cycle", {4'b0, clrReq}, 8'h00);
      ack(2);
      done(2, 1'b1, 4'b0100);
      maskReg = 4'b0;
      DREQ = 4'b0;
      tick();

      // Disable and programming window
      commandReg = 8'h04;
      DREQ = 4'b0001;
      repeat (4) tick();
      chk("dis_busy", {7'b0, busy}, 8'd0);
      commandReg = 8'h00;
      Program = 1'b1;
      repeat (4) tick();
      chk("prog_busy", {7'b0, busy}, 8'd0);
      Program = 1'b0;
      sb.push_back(0);
      wait_grant("unblock", lat);
      chk("unblock_lat", 8'(lat), 8'd1);
      ack(0);
      Program = 1'b1;
      commandReg = 8'h04;
      maskReg = 4'b0001;
      tick(); tick();
      chk("midsvc_dack", {4'b0, DACK}, 8'h0e);
      chk("midsvc_valid", {4'b0, VALID_DREQ}, 8'h01);
      done(0, 1'b0, 4'b0001);
      repeat (3) tick();
      chk("midsvc_blocked", {7'b0, busy}, 8'd0);
      Program = 1'b0;
      commandReg = 8'h00;
      maskReg = 4'b0;
      DREQ = 4'b0;
      tick(); tick();

      // Polarity
      commandReg = 8'hC0;
      DREQ = 4'b1110;
      sb.push_back(0);
      wait_grant("pol", lat);
      ack(0);
      chk("pol_dack", {4'b0, DACK}, 8'h01);
      done(0, 1'b0, 4'b1111);
      commandReg = 8'h00;
      DREQ = 4'b0000;
      tick(); tick();

      // Reset mid-service
      DREQ = 4'b0010;
      sb.push_back(1);
      wait_grant("rstsvc", lat);
      ack(1);
      RESET_N = 1'b0;
      tick();
      chk("rstsvc_busy", {7'b0, busy}, 8'd0);
      chk("rstsvc_dack", {4'b0, DACK}, 8'h0f);
      chk("rstsvc_valid", {4'b0, VALID_DREQ}, 8'h00);
      chk("rstsvc_ch", {6'b0, activeCh}, 8'd0);
      RESET_N = 1'b1;
      DREQ = 4'b0;
      tick();

      chk("sb_empty", 8'(sb.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
